ahblite_slave_mux: RTL and testbench
====================================

Name: ahblite_slave_mux

Overview:
- AHB-Lite response multiplexer and default slave for the Cortex-M0 system bus.
- Sits directly downstream of the address decoder. It consumes the four port select lines P0..P3_HSEL (RAMCODE, RAMDATA, Keyboard, LCD) in the address phase.
- Returns the data-phase HRDATA/HREADYOUT/HRESP of the selected slave to the master.
- Generates the two-cycle ERROR response for unmapped addresses.
- Contains a stall watchdog that aborts a hung data phase.

Parameters:
- Port0_en, 1, enable port 0; when 0 the port is never selected and its inputs are ignored.
- Port1_en, 1, enable port 1.
- Port2_en, 1, enable port 2.
- Port3_en, 1, enable port 3.
- TIMEOUT_CYC, 1024, data-phase wait-cycle limit before abort; range 2..65535.
- TIMEOUT_EN, 1, 0 disables the watchdog entirely.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- HREADY  input  1  bus HREADY, this block's HREADYOUT fed back; address phase completes when high.
- HTRANS  input  2  master transfer type; bit1=1 means NONSEQ/SEQ.
- P0_HSEL..P3_HSEL  input  1 each  decoder selects, address phase.
- P0_HREADYOUT..P3_HREADYOUT  input  1 each  slave ready.
- P0_HRESP..P3_HRESP  input  1 each  slave response.
- P0_HRDATA..P3_HRDATA  input  32 each  slave read data.
- HREADYOUT  output  1  to master.
- HRESP  output  1  to master.
- HRDATA  output  32  to master.
- TIMEOUT_FLAG  output  1  sticky watchdog-fired indicator.

Behaviour:
All registers are async-cleared by HRESETn low, effective immediately, including mid-transfer.
- Data-phase select register dsel is one-hot over {P0, P1, P2, P3, DEF, NONE}.
  - Reset value: NONE.
  - Updated only on rising HCLK with HREADY=1.
  - Next value is the highest-priority asserted enabled HSEL, in priority order P0>P1>P2>P3.
  - If no enabled HSEL is asserted and HTRANS[1]=1, next value is DEF.
  - Otherwise next value is NONE.
  - Multiple HSELs asserted at once are resolved by that priority; this is not an error.
- Output mux is combinational from dsel:
  - Px: HRDATA/HREADYOUT/HRESP equal the Px inputs.
  - NONE: HREADYOUT=1, HRESP=0, HRDATA=0 (IDLE/BUSY to any address completes zero-wait OKAY).
  - DEF: HRDATA=0 and the default-slave FSM drives HREADYOUT/HRESP.
- Reset output values: HREADYOUT=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0.
- Default-slave / abort FSM states: IDLE, ERR1, ERR2.
  - IDLE: pass-through per the mux above.
  - Entry to ERR1 occurs on either condition:
    - the next dsel is DEF; the ERR1 cycle is the first data-phase cycle;
    - a watchdog fire.
  - ERR1 drives HREADYOUT=0, HRESP=1. Always advances to ERR2 next cycle.
  - ERR2 drives HREADYOUT=1, HRESP=1. Returns to IDLE next cycle; dsel is reloaded by the normal HREADY=1 rule.
  - Because ERR2 completes the phase, a new address phase accepted in ERR2 captures normally. An unmapped NONSEQ there re-enters ERR1 back-to-back.
- Watchdog (TIMEOUT_EN=1):
  - 16-bit counter wcnt clears whenever HREADYOUT=1 or dsel is NONE/DEF.
  - Otherwise wcnt increments each cycle.
  - When wcnt reaches TIMEOUT_CYC-1 while still stalled:
    - the FSM enters ERR1;
    - the output mux detaches from the slave (dsel forced to DEF for the ERR sequence);
    - TIMEOUT_FLAG is set.
  - TIMEOUT_FLAG clears only on reset.
  - A stalled slave is not otherwise notified. Its later HREADYOUT is ignored, since it is no longer selected.
  - If the slave raises HREADYOUT in the same cycle the limit is reached, the slave wins: normal completion, no abort.
- Disabled port (Portx_en=0): its HSEL is treated as 0, so an access to it is answered by the default slave with ERROR.

Test Plan:
- Reset, then NONSEQ read 0x0000_0010 with P0_HSEL=1, then P0_HRDATA=0xDEADBEEF, P0_HREADYOUT=1 -> HRDATA=0xDEADBEEF, HRESP=0, one-cycle data phase.
- P1 read with P1_HREADYOUT low for 3 cycles -> HREADYOUT low for exactly 3 cycles, then HRDATA=P1_HRDATA. HSEL changes on P2 during the wait are ignored until HREADY=1.
- NONSEQ to 0x3000_0000 (no HSEL) -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, HRDATA=0. IDLE to the same address -> zero-wait OKAY.
- TIMEOUT_CYC=8, P3 HREADYOUT held low -> ERR1 after 8 stalled cycles (counter 0..7), ERR2 next cycle, TIMEOUT_FLAG=1 and stays high. A subsequent P0 access completes normally.
- Port2_en=0, NONSEQ with P2_HSEL=1 -> two-cycle ERROR. Same access with P0_HSEL and P2_HSEL both high, all ports enabled -> P0 data returned.
- HRESETn asserted during P1 wait state -> outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0. After release, first transfer decodes normally.

Source files
------------

// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite bus bundle between the address decoder / four slaves and the response mux.
// The slave modport is the mux side; the master modport is the bus fabric side.
interface ahblite_slave_mux_if;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL;
    logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT;
    logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP;
    logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        TIMEOUT_FLAG;

    modport slave (
        input  HREADY, HTRANS,
        input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        output HREADYOUT, HRESP, HRDATA, TIMEOUT_FLAG
    );

    modport master (
        output HREADY, HTRANS,
        output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        input  HREADYOUT, HRESP, HRDATA, TIMEOUT_FLAG
    );
endinterface

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response mux for four slaves, with built-in default slave (two-cycle ERROR)
// and a data-phase stall watchdog that aborts a hung slave with the same ERROR sequence.
module ahblite_slave_mux #(
    parameter bit          Port0_en    = 1'b1,
    parameter bit          Port1_en    = 1'b1,
    parameter bit          Port2_en    = 1'b1,
    parameter bit          Port3_en    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter bit          TIMEOUT_EN  = 1'b1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahblite_slave_mux_if.slave bus
);
    localparam int          NPORT   = 4;
    localparam int          D_DEF   = 4;
    localparam logic [5:0]  SEL_DEF  = 6'b01_0000;
    localparam logic [5:0]  SEL_NONE = 6'b10_0000;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_ERR1 = 2'd1;
    localparam logic [1:0]  ST_ERR2 = 2'd2;
    localparam logic [NPORT-1:0] PORT_EN  = {Port3_en, Port2_en, Port1_en, Port0_en};
    localparam logic [15:0]      WD_LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [NPORT-1:0]       hsel, s_rdy, s_resp;
    logic [NPORT-1:0][31:0] s_data;
    logic                   unused_htrans0;

    assign hsel   = {bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL} & PORT_EN;
    assign s_rdy  = {bus.P3_HREADYOUT, bus.P2_HREADYOUT, bus.P1_HREADYOUT, bus.P0_HREADYOUT};
    assign s_resp = {bus.P3_HRESP, bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
    assign s_data = {bus.P3_HRDATA, bus.P2_HRDATA, bus.P1_HRDATA, bus.P0_HRDATA};
    assign unused_htrans0 = bus.HTRANS[0];

    logic [5:0]  dsel_q, dsel_d, dsel_dec;
    logic [1:0]  state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        flag_q, flag_d;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;
    logic        stalled, wd_fire, accept;

    // Lowest port index wins; no enabled select on an active transfer goes to the default slave.
    always_comb begin
        dsel_dec = bus.HTRANS[1] ? SEL_DEF : SEL_NONE;
        for (int i = NPORT-1; i >= 0; i--) begin
            if (hsel[i]) begin
                dsel_dec    = '0;
                dsel_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel_q[i]) begin
                hreadyout = s_rdy[i];
                hresp     = s_resp[i];
                hrdata    = s_data[i];
            end
        end
        case (state_q)
            ST_ERR1: begin hreadyout = 1'b0; hresp = 1'b1; hrdata = '0; end
            ST_ERR2: begin hreadyout = 1'b1; hresp = 1'b1; hrdata = '0; end
            default: ;
        endcase
    end

    // A slave that raises HREADYOUT on the limit cycle is not stalled, so it completes normally.
    assign stalled = (state_q == ST_IDLE) && (|dsel_q[NPORT-1:0]) && !hreadyout;
    assign wd_fire = TIMEOUT_EN && stalled && (wcnt_q == WD_LIMIT);
    assign accept  = bus.HREADY && (state_q != ST_ERR1);

    always_comb begin
        wcnt_d = '0;
        if (TIMEOUT_EN && stalled && !wd_fire)
            wcnt_d = wcnt_q + 16'd1;
    end

    always_comb begin
        state_d = ST_IDLE;
        dsel_d  = dsel_q;
        flag_d  = flag_q | wd_fire;
        if (wd_fire) begin
            state_d = ST_ERR1;
            dsel_d  = SEL_DEF;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            dsel_d = dsel_dec;
            if (dsel_dec[D_DEF])
                state_d = ST_ERR1;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q  <= SEL_NONE;
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            dsel_q  <= dsel_d;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.HREADYOUT    = hreadyout;
    assign bus.HRESP        = hresp;
    assign bus.HRDATA       = hrdata;
    assign bus.TIMEOUT_FLAG = flag_q;
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: three parameterizations driven by shared stimulus,
// each checked every cycle against a transfer-level reference model.
module tb_ahblite_slave_mux;
  localparam int TCYC = 8;
  localparam int NDUT = 3;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [1:0]       htrans;
  logic [3:0]       hsel, s_rdy, s_resp;
  logic [3:0][31:0] s_data;

  logic [NDUT-1:0]       o_rdy, o_resp, o_flag;
  logic [NDUT-1:0][31:0] o_data;

  ahblite_slave_mux_if bus_if [NDUT] ();

  for (genvar k = 0; k < NDUT; k++) begin : g_wire
    assign bus_if[k].HREADY       = bus_if[k].HREADYOUT;
    assign bus_if[k].HTRANS       = htrans;
    assign bus_if[k].P0_HSEL      = hsel[0];
    assign bus_if[k].P1_HSEL      = hsel[1];
    assign bus_if[k].P2_HSEL      = hsel[2];
    assign bus_if[k].P3_HSEL      = hsel[3];
    assign bus_if[k].P0_HREADYOUT = s_rdy[0];
    assign bus_if[k].P1_HREADYOUT = s_rdy[1];
    assign bus_if[k].P2_HREADYOUT = s_rdy[2];
    assign bus_if[k].P3_HREADYOUT = s_rdy[3];
    assign bus_if[k].P0_HRESP     = s_resp[0];
    assign bus_if[k].P1_HRESP     = s_resp[1];
    assign bus_if[k].P2_HRESP     = s_resp[2];
    assign bus_if[k].P3_HRESP     = s_resp[3];
    assign bus_if[k].P0_HRDATA    = s_data[0];
    assign bus_if[k].P1_HRDATA    = s_data[1];
    assign bus_if[k].P2_HRDATA    = s_data[2];
    assign bus_if[k].P3_HRDATA    = s_data[3];
    assign o_rdy[k]  = bus_if[k].HREADYOUT;
    assign o_resp[k] = bus_if[k].HRESP;
    assign o_data[k] = bus_if[k].HRDATA;
    assign o_flag[k] = bus_if[k].TIMEOUT_FLAG;
  end

  // 0: all ports, short watchdog; 1: port 2 disabled; 2: watchdog off
  ahblite_slave_mux #(.TIMEOUT_CYC(TCYC)) dut_a (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if[0]));
  ahblite_slave_mux #(.Port2_en(1'b0), .TIMEOUT_CYC(TCYC)) dut_b (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if[1]));
  ahblite_slave_mux #(.TIMEOUT_EN(1'b0)) dut_c (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if[2]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: what the current data phase is talking to (0..3 slave, 4 default slave, 5 nothing),
  // which error-response cycle we are in (0 none, 1 first, 2 second), stalled cycles so far.
  int m_sel  [NDUT];
  int m_err  [NDUT];
  int m_wait [NDUT];
  bit m_flag [NDUT];

  function automatic logic [3:0] en_of(input int k);
    return (k == 1) ? 4'b1011 : 4'b1111;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_sel[k] = 5; m_err[k] = 0; m_wait[k] = 0; m_flag[k] = 1'b0;
    end
  endtask

  task automatic model_eval(input int k, output logic r, output logic p, output logic [31:0] d);
    if (m_err[k] == 1)      begin r = 1'b0; p = 1'b1; d = '0; end
    else if (m_err[k] == 2) begin r = 1'b1; p = 1'b1; d = '0; end
    else if (m_sel[k] < 4)  begin r = s_rdy[m_sel[k]]; p = s_resp[m_sel[k]]; d = s_data[m_sel[k]]; end
    else                    begin r = 1'b1; p = 1'b0; d = '0; end
  endtask

  task automatic model_step(input int k);
    logic r, p;
    logic [31:0] d;
    logic [3:0] live;
    int pick;
    model_eval(k, r, p, d);
    if (m_err[k] == 0 && m_sel[k] < 4 && !r) begin
      if (k != 2 && m_wait[k] == TCYC-1) begin
        m_err[k] = 1; m_sel[k] = 4; m_flag[k] = 1'b1; m_wait[k] = 0;
      end else begin
        m_wait[k]++;
      end
      return;
    end
    m_wait[k] = 0;
    if (m_err[k] == 1) begin
      m_err[k] = 2;
      return;
    end
    live = hsel & en_of(k);
    pick = 5;
    for (int j = 3; j >= 0; j--) if (live[j]) pick = j;
    m_err[k] = 0;
    if (pick == 5 && htrans[1]) begin
      pick = 4;
      m_err[k] = 1;
    end
    m_sel[k] = pick;
  endtask

  logic [NDUT-1:0]       lr, lp, lf;
  logic [NDUT-1:0][31:0] ld;

  task automatic cycle();
    logic r, p;
    logic [31:0] d;
    @(negedge HCLK);
    for (int k = 0; k < NDUT; k++) begin
      model_eval(k, r, p, d);
      chk($sformatf("rdy%0d", k),  o_rdy[k],  r);
      chk($sformatf("resp%0d", k), o_resp[k], p);
      chk($sformatf("data%0d", k), o_data[k], d);
      chk($sformatf("flag%0d", k), o_flag[k], m_flag[k]);
      lr[k] = o_rdy[k]; lp[k] = o_resp[k]; ld[k] = o_data[k]; lf[k] = o_flag[k];
    end
    for (int k = 0; k < NDUT; k++) model_step(k);
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    hsel = '0; htrans = 2'b00;
  endtask

  int lowcnt;
  int stall_left [4];

  initial begin
    HRESETn = 1'b0;
    idle_bus();
    s_rdy = 4'hF; s_resp = '0;
    s_data[0] = 32'h0101_0101; s_data[1] = 32'h1111_2222;
    s_data[2] = 32'h5555_6666; s_data[3] = 32'h7777_8888;
    model_reset();
    repeat (2) @(negedge HCLK);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_rdy", o_rdy[k], 1); chk("rst_resp", o_resp[k], 0);
      chk("rst_data", o_data[k], 0); chk("rst_flag", o_flag[k], 0);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // zero-wait P0 read
    hsel = 4'b0001; htrans = 2'b10; s_data[0] = 32'hDEAD_BEEF;
    cycle();
    idle_bus();
    cycle();
    chk("p0_data", ld[0], 32'hDEAD_BEEF); chk("p0_resp", lp[0], 0); chk("p0_rdy", lr[0], 1);

    // P1 with three wait states; P2 select during the wait must not be taken
    hsel = 4'b0010; htrans = 2'b10;
    cycle();
    lowcnt = 0;
    for (int i = 0; i < 8; i++) begin
      s_rdy[1] = (i >= 3);
      hsel   = (i < 3) ? 4'b0100 : 4'b0000;
      htrans = (i < 3) ? 2'b10 : 2'b00;
      cycle();
      if (lr[0]) break;
      lowcnt++;
    end
    chk("p1_wait", lowcnt, 3);
    chk("p1_data", ld[0], 32'h1111_2222);
    idle_bus();
    cycle();
    chk("p2_ignored", ld[0], 0);

    // unmapped NONSEQ, back-to-back unmapped NONSEQ in ERR2, then IDLE
    htrans = 2'b10;
    cycle();
    idle_bus();
    cycle();
    chk("def_err1", {lr[0], lp[0]}, 2'b01);
    htrans = 2'b10;
    cycle();
    chk("def_err2", {lr[0], lp[0]}, 2'b11); chk("def_data", ld[0], 0);
    idle_bus();
    cycle();
    chk("b2b_err1", {lr[0], lp[0]}, 2'b01);
    cycle();
    chk("b2b_err2", {lr[0], lp[0]}, 2'b11);
    cycle();
    chk("idle_okay", {lr[0], lp[0]}, 2'b10);

    // watchdog on a hung P3
    hsel = 4'b1000; htrans = 2'b10;
    cycle();
    idle_bus(); s_rdy[3] = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (lr[0]) break;
      lowcnt++;
    end
    chk("to_lowcnt", lowcnt, 9);
    chk("to_err2_resp", lp[0], 1);
    chk("to_flag", lf[0], 1);
    chk("to_off_flag", lf[2], 0);
    chk("to_off_stall", lr[2], 0);
    s_rdy = 4'hF; hsel = 4'b0001; htrans = 2'b10; s_data[0] = 32'hCAFE_F00D;
    cycle();
    idle_bus();
    cycle();
    chk("post_to_data", ld[0], 32'hCAFE_F00D);
    chk("to_flag_sticky", lf[0], 1);

    // disabled port 2 gets the default slave; P0+P2 resolves to P0
    hsel = 4'b0100; htrans = 2'b10;
    cycle();
    idle_bus();
    cycle();
    chk("p2dis_err1", {lr[1], lp[1]}, 2'b01);
    chk("p2en_data", ld[0], 32'h5555_6666);
    cycle();
    chk("p2dis_err2", {lr[1], lp[1]}, 2'b11);
    hsel = 4'b0101; htrans = 2'b10;
    cycle();
    idle_bus();
    cycle();
    chk("prio_data_a", ld[0], 32'hCAFE_F00D);
    chk("prio_data_b", ld[1], 32'hCAFE_F00D);

    // reset in the middle of a P1 wait state
    hsel = 4'b0010; htrans = 2'b10;
    cycle();
    idle_bus(); s_rdy[1] = 1'b0;
    cycle();
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_rdy", o_rdy[0], 1); chk("mid_rst_resp", o_resp[0], 0);
    chk("mid_rst_data", o_data[0], 0); chk("mid_rst_flag", o_flag[0], 0);
    model_reset();
    HRESETn = 1'b1;
    s_rdy = 4'hF; hsel = 4'b0001; htrans = 2'b10; s_data[0] = 32'h0BAD_F00D;
    cycle();
    idle_bus();
    cycle();
    chk("post_rst_data", ld[0], 32'h0BAD_F00D);

    // random traffic with bursty slave stalls
    for (int j = 0; j < 4; j++) stall_left[j] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++) begin
        if (stall_left[j] == 0 && $urandom_range(0, 9) == 0) stall_left[j] = $urandom_range(1, 12);
        s_rdy[j] = (stall_left[j] == 0);
        if (stall_left[j] > 0) stall_left[j]--;
        s_resp[j] = ($urandom_range(0, 15) == 0);
        s_data[j] = $urandom;
        hsel[j]   = ($urandom_range(0, 3) == 0);
      end
      htrans = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
